// File: rtl/uart_rx_drv.sv
// uart_rx_drv: UART 8N1 receiver feeding the tester FSM.
// Synchronizes the async serial line, samples each bit at mid-bit, checks the
// stop bit and presents each good byte with a one-cycle valid strobe.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority vote on the
// synchronized line, sample point moved one cycle later).
module uart_rx_drv #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_frame_err,
    output logic       out_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_LAST = HALF_BIT;
`else
    localparam int START_LAST = HALF_BIT - 1;
`endif
    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LAST);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       sh, sh_n;
    logic             armed, armed_n;
    logic [7:0]       data_n;
    logic             valid_n;
    logic             ferr_n;
    logic             rx_meta;
    logic             rx_s;
    logic             smp;

    // Two-flop synchronizer bringing the async line into the clock domain.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= in_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // History of the two previous synchronized samples for the majority vote.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign smp = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign smp = rx_s;
`endif

    // State and datapath registers; a reset mid-frame discards the partial byte.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sh            <= '0;
            armed         <= 1'b1;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            sh            <= sh_n;
            armed         <= armed_n;
            out_data      <= data_n;
            out_valid     <= valid_n;
            out_frame_err <= ferr_n;
        end
    end

    // Frame sequencing: start check at half bit, then one sample per bit period.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        armed_n = armed;
        data_n  = out_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s) begin
                    armed_n = 1'b1;
                end
                if (armed && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == START_END) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = smp ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    sh_n  = {smp, sh[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (smp) begin
                        data_n  = sh;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n  = 1'b1;
                        armed_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_drv.sv
// tb_uart_rx_drv: scoreboard bench for uart_rx_drv at 16 clocks per bit.
// Stimulus pushes expected events; a negedge monitor pops and compares them.
module tb_uart_rx_drv;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int         MAJ        = 1;
    localparam logic [7:0] GLITCH_EXP = 8'h0F;
`else
    localparam int         MAJ        = 0;
    localparam logic [7:0] GLITCH_EXP = 8'h07;
`endif
    localparam int LAT = 3 + H + 9 * C + MAJ;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       in_clk;
    logic       in_rst_n;
    logic       in_rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_frame_err;
    logic       out_busy;

    exp_t sb[$];
    exp_t ev;
    int   tests_run     = 0;
    int   tests_failed  = 0;
    int   cycle         = 0;
    int   busy_cycles   = 0;
    int   last_ev_cycle = 0;
    int   prev_ev_cycle = 0;
    int   t_start;

    uart_rx_drv #(
        .CLKS_PER_BIT(C)
    ) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_rx        (in_rx),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_frame_err(out_frame_err),
        .out_busy     (out_busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Free-running cycle counter used for latency and spacing checks.
    always @(posedge in_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every valid or frame-error pulse must match the head of the scoreboard.
    always @(negedge in_clk) begin
        if (out_busy) busy_cycles++;
        if (out_valid || out_frame_err) begin
            prev_ev_cycle = last_ev_cycle;
            last_ev_cycle = cycle;
            checkOutput("valid_err_exclusive", int'(out_valid & out_frame_err), 0);
            checkOutput("event_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                ev = sb.pop_front();
                checkOutput("event_kind", int'(out_frame_err), int'(ev.is_err));
                checkOutput("event_data", int'(out_data), int'(ev.data));
            end
        end
    end

    task automatic idle(input int n);
        in_rx = 1'b1;
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first and stop; optional single-cycle low
    // glitch at the mid-bit cycle of bit glitch_bit; stops after n_cycles.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 input int glitch_bit, input int n_cycles,
                                 output int t0);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        t0 = cycle;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < C; j++) begin
                if (i * C + j >= n_cycles) return;
                in_rx = (i == glitch_bit && j == H) ? 1'b0 : frame[i];
                @(posedge in_clk);
                #1;
            end
        end
    endtask

    initial begin
        in_rst_n = 1'b0;
        in_rx    = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_frame_err", int'(out_frame_err), 0);
        checkOutput("reset_busy", int'(out_busy), 0);
        checkOutput("reset_data", int'(out_data), 0);
        in_rst_n = 1'b1;
        idle(2 * C);

        // Single good byte: data, latency and busy duration.
        sb.push_back('{is_err: 1'b0, data: 8'hA5});
        busy_cycles = 0;
        applyStimulus(8'hA5, 1'b1, -1, 10 * C, t_start);
        idle(C);
        checkOutput("t1_latency", last_ev_cycle - t_start, LAT);
        checkOutput("t1_busy_cycles", busy_cycles, H + 9 * C + MAJ);
        checkOutput("t1_queue_empty", sb.size(), 0);

        // Back-to-back frames with no idle gap.
        sb.push_back('{is_err: 1'b0, data: 8'h00});
        sb.push_back('{is_err: 1'b0, data: 8'hFF});
        applyStimulus(8'h00, 1'b1, -1, 10 * C, t_start);
        applyStimulus(8'hFF, 1'b1, -1, 10 * C, t_start);
        idle(C);
        checkOutput("t2_valid_spacing", last_ev_cycle - prev_ev_cycle, 10 * C);
        checkOutput("t2_queue_empty", sb.size(), 0);

        // Short low pulse is rejected as a false start.
        busy_cycles = 0;
        in_rx = 1'b0;
        repeat (4) begin
            @(posedge in_clk);
            #1;
        end
        idle(10);
        checkOutput("t3_busy_idle", int'(out_busy), 0);
        checkOutput("t3_busy_cycles", busy_cycles, H + MAJ);
        idle(2 * C);
        checkOutput("t3_data_held", int'(out_data), 8'hFF);

        // Framing error with the line stuck low, then a good byte.
        sb.push_back('{is_err: 1'b1, data: 8'hFF});
        sb.push_back('{is_err: 1'b0, data: 8'h11});
        applyStimulus(8'h3C, 1'b0, -1, 10 * C, t_start);
        in_rx = 1'b0;
        repeat (32) begin
            @(posedge in_clk);
            #1;
        end
        idle(2 * C);
        applyStimulus(8'h11, 1'b1, -1, 10 * C, t_start);
        idle(2 * C);
        checkOutput("t4_queue_empty", sb.size(), 0);
        checkOutput("t4_data", int'(out_data), 8'h11);

        // Reset pulse in the middle of data bit 4 of 0x55.
        applyStimulus(8'h55, 1'b1, -1, 5 * C + H, t_start);
        checkOutput("t5_busy_midframe", int'(out_busy), 1);
        in_rst_n = 1'b0;
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        checkOutput("t5_rst_valid", int'(out_valid), 0);
        checkOutput("t5_rst_frame_err", int'(out_frame_err), 0);
        checkOutput("t5_rst_busy", int'(out_busy), 0);
        checkOutput("t5_rst_data", int'(out_data), 0);
        idle(2 * C);
        sb.push_back('{is_err: 1'b0, data: 8'h12});
        applyStimulus(8'h12, 1'b1, -1, 10 * C, t_start);
        idle(2 * C);
        checkOutput("t5_queue_empty", sb.size(), 0);
        checkOutput("t5_data", int'(out_data), 8'h12);

        // One-cycle low glitch on the data bit 3 sample cycle.
        sb.push_back('{is_err: 1'b0, data: GLITCH_EXP});
        applyStimulus(8'h0F, 1'b1, 4, 10 * C, t_start);
        idle(2 * C);
        checkOutput("t6_queue_empty", sb.size(), 0);
        checkOutput("t6_data", int'(out_data), int'(GLITCH_EXP));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
